// File: rtl/count_sequence_monitor_if.sv
// count_sequence_monitor_if
// Groups the monitored count bus and the monitor's status readout.
//   count_in    : count value driven by the counter stage toward the pads
//   count_valid : sample qualifier for count_in
//   clear       : synchronous re-arm of the monitor statistics
//   locked      : monitor currently in the LOCKED state
//   err_flag    : sticky sequence-break indicator
//   err_count   : saturating count of breaks seen while locked
//   wrap_count  : saturating count of max->0 wraps seen while locked
//   state       : encoded FSM state (0 IDLE, 1 SEARCH, 2 LOCKED, 3 ERROR)
// The master modport is the counter/software side, the slave modport is
// the monitor itself.
interface count_sequence_monitor_if #(
  parameter int BITS      = 2,
  parameter int ERR_WIDTH = 8
);
  logic [BITS-1:0]      count_in;
  logic                 count_valid;
  logic                 clear;
  logic                 locked;
  logic                 err_flag;
  logic [ERR_WIDTH-1:0] err_count;
  logic [ERR_WIDTH-1:0] wrap_count;
  logic [1:0]           state;

  modport master (
    output count_in,
    output count_valid,
    output clear,
    input  locked,
    input  err_flag,
    input  err_count,
    input  wrap_count,
    input  state
  );

  modport slave (
    input  count_in,
    input  count_valid,
    input  clear,
    output locked,
    output err_flag,
    output err_count,
    output wrap_count,
    output state
  );
endinterface

// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor
// Checks that the pad counter's output advances by exactly +1 (mod 2^BITS)
// on every valid sample. Locks after LOCK_THRESH consecutive good
// increments, then flags and counts sequence breaks and counts wraps.
// Ports:
//   clk   : sole clock, rising-edge
//   reset : asynchronous, active-high reset
//   mon   : slave side of count_sequence_monitor_if (count bus in,
//           status out)
// The interface instance must use the same BITS / ERR_WIDTH values as
// this module.
module count_sequence_monitor #(
  parameter int BITS        = 2,
  parameter int LOCK_THRESH = 4,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  count_sequence_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  // run only ever needs to reach LOCK_THRESH (the value that triggers lock)
  localparam int RUN_W = $clog2(LOCK_THRESH + 1);

  state_t               state_q, state_d;
  logic [BITS-1:0]      prev_q, prev_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic [ERR_WIDTH-1:0] wrap_q, wrap_d;
  logic                 flag_q, flag_d;

  logic                 sample;
  logic                 match;
  logic [BITS-1:0]      expected;
  logic [RUN_W-1:0]     run_inc;

  // clear wins over a simultaneous valid sample, which is then discarded
  assign sample   = mon.count_valid & ~mon.clear;
  // truncation makes all-ones -> 0 a legal increment
  assign expected = prev_q + BITS'(1);
  assign match    = (mon.count_in == expected);
  assign run_inc  = run_q + RUN_W'(1);

  // Next-state and statistics logic. Everything holds by default; ERROR is
  // the only state that moves without a sample. ERROR shares the SEARCH
  // evaluation so a sample on the edge leaving ERROR is not lost.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    err_d   = err_q;
    wrap_d  = wrap_q;
    flag_d  = flag_q;

    if (sample) begin
      prev_d = mon.count_in;
    end

    if (mon.clear) begin
      state_d = IDLE;
      run_d   = '0;
      err_d   = '0;
      wrap_d  = '0;
      flag_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample) begin
            state_d = SEARCH;
            run_d   = '0;
          end
        end
        SEARCH, ERROR: begin
          state_d = SEARCH;
          if (sample) begin
            if (match) begin
              if (run_inc == RUN_W'(LOCK_THRESH)) begin
                state_d = LOCKED;
                run_d   = '0;
              end else begin
                run_d = run_inc;
              end
            end else begin
              run_d = '0;
            end
          end else if (state_q == ERROR) begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (sample) begin
            if (match) begin
              if ((prev_q == '1) && (wrap_q != '1)) begin
                wrap_d = wrap_q + ERR_WIDTH'(1);
              end
            end else begin
              state_d = ERROR;
              flag_d  = 1'b1;
              if (err_q != '1) begin
                err_d = err_q + ERR_WIDTH'(1);
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and statistics registers; reset acts immediately on assertion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      run_q   <= '0;
      err_q   <= '0;
      wrap_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      flag_q  <= flag_d;
    end
  end

  // Status readout is decoded straight from registered state.
  assign mon.locked     = (state_q == LOCKED);
  assign mon.err_flag   = flag_q;
  assign mon.err_count  = err_q;
  assign mon.wrap_count = wrap_q;
  assign mon.state      = state_q;

endmodule

// File: tb/tb_count_sequence_monitor.sv
// tb_count_sequence_monitor
// Drives two monitors (ERR_WIDTH 8 and ERR_WIDTH 2) from the same count
// stream and compares both against a behavioural model of the monitor
// rules after every clock edge. Directed scenarios come first, then a
// randomized stream of mostly-correct counts with gaps, breaks and clears.
module tb_count_sequence_monitor;

  localparam int BITS = 2;
  localparam int TH   = 4;
  localparam int M    = 1 << BITS;
  localparam int MAXA = 255;
  localparam int MAXB = 3;

  logic            clk;
  logic            reset;
  logic [BITS-1:0] drv_count;
  logic            drv_valid;
  logic            drv_clear;

  int checks;
  int failures;
  int src;

  // behavioural model of the monitor
  bit m_active;
  bit m_locked;
  bit m_errcyc;
  bit m_flag;
  int m_prev;
  int m_streak;
  int m_errs;
  int m_wraps;

  count_sequence_monitor_if #(.BITS(BITS), .ERR_WIDTH(8)) bus_a ();
  count_sequence_monitor_if #(.BITS(BITS), .ERR_WIDTH(2)) bus_b ();

  assign bus_a.count_in    = drv_count;
  assign bus_a.count_valid = drv_valid;
  assign bus_a.clear       = drv_clear;
  assign bus_b.count_in    = drv_count;
  assign bus_b.count_valid = drv_valid;
  assign bus_b.clear       = drv_clear;

  count_sequence_monitor #(.BITS(BITS), .LOCK_THRESH(TH), .ERR_WIDTH(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .mon   (bus_a)
  );

  count_sequence_monitor #(.BITS(BITS), .LOCK_THRESH(TH), .ERR_WIDTH(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .mon   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison point; every check is counted here
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int sat(input int value, input int limit);
    return (value > limit) ? limit : value;
  endfunction

  function automatic int modelState();
    if (!m_active) return 0;
    if (m_errcyc)  return 3;
    if (m_locked)  return 2;
    return 1;
  endfunction

  task automatic modelReset();
    m_active = 0;
    m_locked = 0;
    m_errcyc = 0;
    m_flag   = 0;
    m_prev   = 0;
    m_streak = 0;
    m_errs   = 0;
    m_wraps  = 0;
  endtask

  // one clock edge of the monitor's rules, written in terms of the
  // observable behaviour: idle/active, good streak, locked, error cycle
  task automatic modelStep(input bit v, input bit c, input int cin);
    bit good;
    good = (cin == ((m_prev + 1) % M));
    if (c) begin
      m_active = 0;
      m_locked = 0;
      m_errcyc = 0;
      m_streak = 0;
      m_errs   = 0;
      m_wraps  = 0;
      m_flag   = 0;
    end else if (v) begin
      if (!m_active) begin
        m_active = 1;
        m_streak = 0;
      end else if (m_locked) begin
        if (good) begin
          if (m_prev == M - 1) m_wraps++;
        end else begin
          m_locked = 0;
          m_errcyc = 1;
          m_errs++;
          m_flag = 1;
        end
      end else begin
        m_errcyc = 0;
        if (good) begin
          m_streak++;
          if (m_streak == TH) begin
            m_locked = 1;
            m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end
      m_prev = cin;
    end else if (m_errcyc) begin
      m_errcyc = 0;
      m_streak = 0;
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ":a.state"},  int'(bus_a.state),      modelState());
    checkOutput({tag, ":a.locked"}, int'(bus_a.locked),     int'(m_locked && !m_errcyc));
    checkOutput({tag, ":a.flag"},   int'(bus_a.err_flag),   int'(m_flag));
    checkOutput({tag, ":a.errs"},   int'(bus_a.err_count),  sat(m_errs, MAXA));
    checkOutput({tag, ":a.wraps"},  int'(bus_a.wrap_count), sat(m_wraps, MAXA));
    checkOutput({tag, ":b.state"},  int'(bus_b.state),      modelState());
    checkOutput({tag, ":b.locked"}, int'(bus_b.locked),     int'(m_locked && !m_errcyc));
    checkOutput({tag, ":b.flag"},   int'(bus_b.err_flag),   int'(m_flag));
    checkOutput({tag, ":b.errs"},   int'(bus_b.err_count),  sat(m_errs, MAXB));
    checkOutput({tag, ":b.wraps"},  int'(bus_b.wrap_count), sat(m_wraps, MAXB));
  endtask

  // drive one cycle of inputs, advance the model across the edge and
  // compare just after the edge
  task automatic applyStimulus(input bit v, input bit c, input int cin, input string tag);
    drv_valid = v;
    drv_clear = c;
    drv_count = BITS'(cin);
    @(posedge clk);
    modelStep(v, c, cin);
    #1;
    compareAll(tag);
  endtask

  task automatic feed(input int v, input string tag);
    applyStimulus(1'b1, 1'b0, v, tag);
    src = v;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    src       = 0;
    drv_count = '0;
    drv_valid = 1'b0;
    drv_clear = 1'b0;
    reset     = 1'b1;
    modelReset();
    #17;
    compareAll("reset");
    reset = 1'b0;

    // lock latency and wrap counting
    feed(0, "lock0");
    feed(1, "lock1");
    feed(2, "lock2");
    feed(3, "lock3");
    checkOutput("not_locked_after_4", int'(bus_a.locked), 0);
    feed(0, "lock4");
    checkOutput("locked_after_5", int'(bus_a.locked), 1);
    checkOutput("no_wrap_in_search", int'(bus_a.wrap_count), 0);
    feed(1, "wrap1");
    feed(2, "wrap2");
    feed(3, "wrap3");
    feed(0, "wrap4");
    checkOutput("wrap_counted", int'(bus_a.wrap_count), 1);

    // break while locked with prev=0, then relock
    feed(2, "break");
    checkOutput("break_state", int'(bus_a.state), 3);
    checkOutput("break_errs", int'(bus_a.err_count), 1);
    feed(3, "after_err");
    checkOutput("after_err_state", int'(bus_a.state), 1);
    feed(0, "relock1");
    feed(1, "relock2");
    feed(2, "relock3");
    checkOutput("relocked", int'(bus_a.locked), 1);
    checkOutput("flag_sticky", int'(bus_a.err_flag), 1);

    // valid gaps while locked with prev=1
    feed(3, "pre_gap1");
    feed(0, "pre_gap2");
    feed(1, "pre_gap3");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 3, "gap");
    feed(2, "post_gap");
    checkOutput("gap_still_locked", int'(bus_a.locked), 1);
    checkOutput("gap_no_error", int'(bus_a.err_count), 1);

    // second break to reach err_count=2, relock, then async reset mid-cycle
    feed(0, "b2_bad");
    for (int i = 1; i <= TH; i++) feed(i % M, "b2_good");
    checkOutput("pre_reset_errs", int'(bus_a.err_count), 2);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    compareAll("async_reset");
    @(posedge clk);
    #1;
    compareAll("in_reset");
    #3;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 2, "post_release_idle");
    feed(1, "first_sample");
    checkOutput("first_sample_search", int'(bus_a.state), 1);

    // saturation: five lock/break cycles
    for (int i = 2; i <= TH + 1; i++) feed(i % M, "sat_lock");
    for (int k = 0; k < 5; k++) begin
      feed((src + 2) % M, "sat_bad");
      for (int i = 0; i < TH; i++) feed((src + 1) % M, "sat_good");
    end
    checkOutput("sat_small", int'(bus_b.err_count), 3);
    checkOutput("sat_wide", int'(bus_a.err_count), 5);

    // clear priority over a mismatching sample
    applyStimulus(1'b1, 1'b1, (src + 2) % M, "clear_prio");
    checkOutput("clear_state", int'(bus_a.state), 0);
    checkOutput("clear_errs", int'(bus_a.err_count), 0);
    checkOutput("clear_flag", int'(bus_a.err_flag), 0);
    feed(0, "after_clear");
    checkOutput("after_clear_state", int'(bus_a.state), 1);

    // randomized stream
    for (int n = 0; n < 1500; n++) begin
      int r;
      int v;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        applyStimulus(1'b1, 1'b1, int'($urandom_range(0, M - 1)), "rnd_clear");
      end else if (r < 22) begin
        applyStimulus(1'b0, 1'b0, int'($urandom_range(0, M - 1)), "rnd_gap");
      end else begin
        if ($urandom_range(0, 7) == 0) v = int'($urandom_range(0, M - 1));
        else v = (src + 1) % M;
        feed(v, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_sequence_monitor.md
# count_sequence_monitor

Downstream checker for the user-area pad counter: samples the `BITS`-wide count bus the counter drives toward the I/O pads and verifies it advances by exactly +1 (mod 2^BITS) on every valid sample. It acquires lock after a run of good increments and flags and counts sequence breaks. It also counts wrap-arounds observed while locked, exposing sticky/saturating status for LA or pad readout.

## Interface
- `BITS`, 2, width of the monitored count bus (≥1)
- `LOCK_THRESH`, 4, consecutive good increments needed to lock (≥1)
- `ERR_WIDTH`, 8, width of `err_count` and `wrap_count` (≥1)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `count_in`  in  BITS  count value from the counter stage
- `count_valid`  in  1  sample qualifier; low = ignore `count_in` this cycle
- `clear`  in  1  synchronous re-arm: clears statistics, returns to IDLE
- `locked`  out  1  high while state is LOCKED
- `err_flag`  out  1  sticky; set on any break detected in LOCKED
- `err_count`  out  ERR_WIDTH  breaks detected in LOCKED, saturating
- `wrap_count`  out  ERR_WIDTH  max→0 transitions matched in LOCKED, saturating
- `state`  out  2  FSM state: 0 IDLE, 1 SEARCH, 2 LOCKED, 3 ERROR

## Operation
- Internal registers:
  - `prev` (BITS): last accepted sample.
  - `run`: good-increment counter, width sufficient to hold LOCK_THRESH.
- Expected value = `prev + 1`, truncated to BITS bits (all-ones → 0 is a match).
- A "sample" is a rising edge with `count_valid`=1 and `clear`=0. Every sample loads `prev <= count_in`.
- With no sample, all registers hold. This includes `state`, except ERROR, which always leaves after one cycle.
- FSM:
  - IDLE: on sample, go to SEARCH with `run`=0. No comparison is made.
  - SEARCH: on a matching sample, `run`+1. If `run`+1 == LOCK_THRESH, go to LOCKED and set `run`=0. On a mismatch, `run`=0 and stay in SEARCH.
  - LOCKED: on a match, stay. If `prev`==all-ones, `wrap_count`+1 (saturating). On a mismatch, go to ERROR: `err_flag`=1, `err_count`+1 (saturating).
  - ERROR: the next edge always goes to SEARCH. If that edge carries a sample, it is evaluated with SEARCH rules; otherwise `run`=0.
- `clear` (edge with `clear`=1): go to IDLE; `run`, `err_count`, `wrap_count`, and `err_flag` all go to 0; `prev` holds. Takes priority over a simultaneous sample, which is discarded.
- Saturation: counters stop at 2^ERR_WIDTH−1 and never roll over.
- Wraps seen in SEARCH are not counted. Mismatches in SEARCH are not counted as errors.
- Re-entering LOCKED after an error does not clear `err_flag`. Only `clear` or `reset` clears it.
- If the counter stage is reset mid-stream, its count jumps to 0 and the monitor reports it as an ordinary break. Software issues `clear` if that break is intentional.

## Timing
- Reset values: `state`=IDLE (0), `locked`=0, `err_flag`=0, `err_count`=0, `wrap_count`=0, `prev`=0, `run`=0. Reset takes effect immediately on assertion, independent of `clk`.
- Release of `reset`: the first edge after deassertion may take a sample.
- All outputs are registered. A sample at edge N is reflected on the outputs after edge N.
- Comparison is combinational on `count_in` vs `prev`, with no input pipeline stage.
- Lock latency from IDLE with a continuously valid, correct sequence: LOCK_THRESH+1 samples. `locked` rises after the (LOCK_THRESH+1)th sample edge.
- A break is visible one edge after the bad sample: `locked`=0, `state`=3.
- ERROR is held for exactly one cycle.
- `count_in` and `count_valid` must be synchronous to `clk`. No handshake back to the source exists: the monitor never stalls the counter.

## Test plan
- Async reset: assert `reset` mid-clock while in LOCKED with `err_count`=2 → all outputs 0 and `state`=0 before the next edge; they remain so until the first sample after release.
- Lock and wrap (BITS=2, LOCK_THRESH=4), valid every cycle:
  - Feed 0,1,2,3,0 → `locked`=1 after the 5th edge, `wrap_count`=0.
  - Continue 1,2,3,0 → `wrap_count`=1.
- Break:
  - When locked with `prev`=0, feed 2 → next cycle `state`=3, `err_flag`=1, `err_count`=1, `locked`=0.
  - Feed 3 → `state`=1 with `run`=1.
  - Feed 0,1,2 → relocked after the 4th good increment; `err_flag` still 1.
- Valid gaps: while locked with `prev`=1, drop `count_valid` for 3 cycles with `count_in`=3 → no output change. Then valid sample 2 → still locked, no error.
- Saturation (ERR_WIDTH=2): force 5 lock/break cycles → `err_count` stops at 3.
- Clear priority: `clear`=1 with `count_valid`=1 and a mismatching value → `state`=0, `err_count`=0, `wrap_count`=0, `err_flag`=0, no error recorded. The next sample moves the FSM to SEARCH.
